// File: rtl/prog_loader_if.sv
// Byte-stream input and memory write port of the program loader.
// master = stream source / memory side, slave = loader.
interface prog_loader_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Byte-serial program loader: framed stream -> sequential 32-bit memory writes,
// XOR checksum gate on cpu_run. Optional inter-byte timeout: LOADER_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | discard bytes until SYNC
// HDR    | collect ADDR_HI, ADDR_LO, CNT_HI, CNT_LO
// DATA   | assemble words MSB first, write each complete word
// CHK    | compare received checksum byte with running XOR
// DONE   | load ok, cpu_run held until reset
// ERR    | load failed, err_code held until reset
module prog_loader #(
  parameter int         ADDR_W    = 10,
  parameter int         MEM_DEPTH = 1024,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
`ifdef LOADER_TIMEOUT_EN
  , parameter int       TIMEOUT_CYC = 4096
`endif
) (
  input  logic              clk1,
  input  logic              rst,
  prog_loader_if.slave      bus,
  output logic              load_busy,
  output logic              cpu_run,
  output logic              load_err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   word_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  err_nxt;
  logic [1:0]  byte_idx;
  logic [15:0] start_addr;
  logic [15:0] count;
  logic [15:0] cnt_full;
  logic [16:0] range_sum;
  logic [7:0]  xor_acc;
  logic [23:0] word_sr;
  logic        accept;
  logic        busy;
  logic        range_bad;
  logic        last_word;

  assign busy         = (state == S_HDR) || (state == S_DATA) || (state == S_CHK);
  // Held low while rst is asserted so no byte is taken during reset.
  assign bus.in_ready = !rst && (state != S_DONE) && (state != S_ERR);
  assign accept       = bus.in_valid && bus.in_ready;

  assign load_busy = busy;
  assign cpu_run   = (state == S_DONE);
  assign load_err  = (state == S_ERR);

  // Range check uses the CNT_LO byte on the bus, before it is registered.
  assign cnt_full  = {count[15:8], bus.in_data};
  assign range_sum = {1'b0, start_addr} + {1'b0, cnt_full};
  assign range_bad = (cnt_full == 16'd0) || (range_sum > 17'(MEM_DEPTH));
  assign last_word = ((16'(word_cnt) + 16'd1) == count);

`ifdef LOADER_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT_CYC + 1);
  logic [GAP_W-1:0] gap;
  logic             gap_tc;

  assign gap_tc = busy && !accept && (gap == '0);

  always_ff @(posedge clk1) begin
    if (rst || accept || !busy) gap <= GAP_W'(TIMEOUT_CYC);
    else if (gap != '0)         gap <= gap - 1'b1;
  end
`endif

  always_comb begin
    state_nxt = state;
    err_nxt   = err_code;
    case (state)
      S_IDLE: if (accept && (bus.in_data == SYNC_BYTE)) state_nxt = S_HDR;
      S_HDR: begin
        if (accept && (byte_idx == 2'd3)) begin
          if (range_bad) begin
            state_nxt = S_ERR;
            err_nxt   = 2'd2;
          end else begin
            state_nxt = S_DATA;
          end
        end
      end
      S_DATA: if (accept && (byte_idx == 2'd3) && last_word) state_nxt = S_CHK;
      S_CHK: begin
        if (accept) begin
          if (bus.in_data == xor_acc) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_ERR;
            err_nxt   = 2'd1;
          end
        end
      end
      S_DONE:  state_nxt = S_DONE;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_IDLE;
    endcase
`ifdef LOADER_TIMEOUT_EN
    if (gap_tc) begin
      state_nxt = S_ERR;
      err_nxt   = 2'd3;
    end
`endif
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state         <= S_IDLE;
      err_code      <= 2'd0;
      byte_idx      <= 2'd0;
      start_addr    <= 16'd0;
      count         <= 16'd0;
      xor_acc       <= 8'd0;
      word_sr       <= 24'd0;
      word_cnt      <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= 32'd0;
    end else begin
      state      <= state_nxt;
      err_code   <= err_nxt;
      bus.mem_we <= 1'b0;
      if (accept) begin
        case (state)
          S_IDLE: begin
            if (bus.in_data == SYNC_BYTE) begin
              xor_acc  <= 8'd0;
              word_cnt <= '0;
              byte_idx <= 2'd0;
            end
          end
          S_HDR: begin
            xor_acc  <= xor_acc ^ bus.in_data;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0:    start_addr[15:8] <= bus.in_data;
              2'd1:    start_addr[7:0]  <= bus.in_data;
              2'd2:    count[15:8]      <= bus.in_data;
              default: count[7:0]       <= bus.in_data;
            endcase
          end
          S_DATA: begin
            xor_acc  <= xor_acc ^ bus.in_data;
            word_sr  <= {word_sr[15:0], bus.in_data};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= start_addr[ADDR_W-1:0] + word_cnt[ADDR_W-1:0];
              bus.mem_wdata <= {word_sr, bus.in_data};
              word_cnt      <= word_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
